digit_scan: RTL and testbench
=============================

// Module: digit_scan
// PURPOSE
//   Upstream feeder for the 7-segment digit decoder. Captures a 14-bit binary
//   value and converts it to 4 BCD digits with a sequential double-dabble.
//   Time-multiplexes the digits onto one shared 4-bit digit bus plus active-low
//   anode strobes. The digit bus drives the decoder's 4-bit input directly.
// PARAMETERS
//   REFRESH_DIV  100000  clk cycles per digit slot (>=2); 1 kHz slot rate at 100 MHz
//   BLANK_LZ     1       1: blank leading-zero slots; 0: show all 4 digits
// PORTS
//   clk    in   1   single system clock, rising edge
//   rst    in   1   synchronous reset, active-high
//   value  in   14  binary value to display, sampled when load accepted
//   load   in   1   request conversion of value (single-cycle pulse expected)
//   digit  out  4   BCD digit of current slot, to decoder input (0..9 only)
//   an     out  4   anode strobes, active-low one-hot; 4'b1111 = slot blanked
//   busy   out  1   conversion in progress; load ignored while high
//   ovf    out  1   last accepted value exceeded 9999 (display saturated)
// BEHAVIOUR
//   Reset, sampled at a clk edge, aborts any conversion and sets:
//     busy=0, ovf=0, display digits d3..d0=0, slot idx=0, tick=0.
//     Outputs: an=4'b1110, digit=0.
//   Reset mid-conversion:
//     - partial result discarded; display stays 0.
//     - a load in the same cycle as rst is ignored.
//   Conversion FSM, states IDLE -> SHIFT -> COMMIT -> IDLE:
//     - IDLE: load=1 at edge N captures value and sets busy=1 from N.
//       If value>9999, captures 9999 and sets ovf_pending.
//     - SHIFT: 14 iterations on edges N+1..N+14. Each iteration:
//       add 3 to any BCD nibble >=5, then shift left by 1.
//     - COMMIT at edge N+15: d3..d0 <= BCD result, ovf <= ovf_pending,
//       busy <= 0. Load-to-display latency is 15 cycles.
//   load while busy: ignored and not queued. load in the COMMIT cycle is also
//     ignored; a new load is accepted from edge N+16.
//   ovf holds until the next accepted load commits.
//   Display digits change only at COMMIT; during conversion the old value
//     continues to be shown.
//   Scan (independent of the FSM):
//     - tick counts 0..REFRESH_DIV-1.
//     - At tick=REFRESH_DIV-1: tick wraps to 0 and idx <= (idx+1) mod 4,
//       so idx goes 3 -> 0.
//     - digit = d[idx].
//     - an = ~(4'b0001 << idx), unless the slot is blanked, in which case
//       an = 4'b1111.
//     - digit and an are decoded from registers only: no combinational path
//       from value or load.
//   Blanking (BLANK_LZ=1):
//     - slot k (k>=1) blanks when d3..dk are all zero.
//     - slot 0 is never blanked, so value 0 shows "0".
//   A COMMIT does not disturb tick or idx; new digits appear at the current slot.
//   Arithmetic: 14-bit shift register plus 16-bit BCD register; no truncation,
//     since 9999 fits in 4 nibbles.
// TESTING  (REFRESH_DIV=4 in simulation)
//   1. rst for 2 cycles -> an=1110, digit=0, busy=0, ovf=0; an then steps
//      1110,1101,1011,0111 every 4 cycles (BLANK_LZ=0).
//   2. load value=1234 -> busy=1 for exactly 15 cycles; then slots 0..3 show
//      digit 4,3,2,1 with an 1110,1101,1011,0111.
//   3. load 12000 -> display 9,9,9,9 and ovf=1; then load 5 -> ovf=0,
//      slot0 digit=5.
//   4. BLANK_LZ=1, load 7 -> slot0 an=1110 digit=7; slots 1-3 an=1111.
//      Load 0 -> slot0 shows 0. Load 1005 -> no slot blanked (inner zeros shown).
//   5. Pulse load=1 at cycles 3 and 9 after an accepted load of 42 -> second
//      pulse ignored; display=42.
//   6. Assert rst 7 cycles into a load of 8888 -> busy=0, display 0, an=1110;
//      8888 never appears.

Source files
------------

// File: rtl/digit_scan.sv
// 14-bit binary to 4-digit BCD via sequential double-dabble, time-multiplexed onto a shared digit bus with active-low anodes.
// Latency: 15 cycles from accepted load to display update; load is ignored (not queued) while busy.
module digit_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] value,
    input  logic        load,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        busy,
    output logic        ovf
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    iter;
    logic [13:0]   sh;
    logic [15:0]   bcd;
    logic [15:0]   bcd_adj;
    logic          ovf_pend;
    logic [15:0]   disp;
    logic [TW-1:0] tick;
    logic [1:0]    idx;
    logic          blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (iter == 4'd13) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iter     <= 4'd0;
            sh       <= 14'd0;
            bcd      <= 16'd0;
            ovf_pend <= 1'b0;
            disp     <= 16'd0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sh       <= (value > 14'd9999) ? 14'd9999 : value;
                        ovf_pend <= (value > 14'd9999);
                        bcd      <= 16'd0;
                        iter     <= 4'd0;
                    end
                end
                SHIFT: begin
                    {bcd, sh} <= {bcd_adj[14:0], sh, 1'b0};
                    iter      <= iter + 4'd1;
                end
                COMMIT: begin
                    disp <= bcd;
                    ovf  <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

    // Slot scan runs free of the converter so a commit never glitches the refresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= '0;
            idx  <= 2'd0;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
            idx  <= idx + 2'd1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    always_comb begin
        blank = 1'b0;
        digit = disp[3:0];
        case (idx)
            2'd0: digit = disp[3:0];
            2'd1: begin
                digit = disp[7:4];
                blank = (disp[15:4] == 12'd0);
            end
            2'd2: begin
                digit = disp[11:8];
                blank = (disp[15:8] == 8'd0);
            end
            2'd3: begin
                digit = disp[15:12];
                blank = (disp[15:12] == 4'd0);
            end
            default: ;
        endcase
        if (BLANK_LZ && blank) begin
            an = 4'b1111;
        end else begin
            an = ~(4'b0001 << idx);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_digit_scan.sv
// Scoreboard bench for digit_scan: one instance with leading-zero blanking, one without, driven identically.
module tb_digit_scan;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic [3:0]  digit0, an0, digit1, an1;
    logic        busy0, ovf0, busy1, ovf1;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit ovf_q[$];

    digit_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .digit(digit0), .an(an0), .busy(busy0), .ovf(ovf0)
    );

    digit_scan #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .digit(digit1), .an(an1), .busy(busy1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        value = 14'(v);
        load  = 1'b1;
        step();
        load  = 1'b0;
        exp_q.push_back((v > 9999) ? 9999 : v);
        ovf_q.push_back(v > 9999);
    endtask

    // Counts busy cycles after an accepted load; optionally pulses load at cycles 3, 9 and the commit edge.
    task automatic wait_commit(input bit pulses);
        int cnt = 0;
        while (busy0 === 1'b1 && cnt < 40) begin
            cnt++;
            if (pulses && (cnt == 3 || cnt == 9 || cnt == 15)) begin
                value = 14'd7777;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            step();
        end
        load = 1'b0;
        checks++;
        if (cnt !== 15) begin
            errors++;
            $display("FAIL busy_len got %0d cycles expected 15", cnt);
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL busy1_done got %b expected 0", busy1);
        end
    endtask

    task automatic wait_slot(input int k);
        logic [3:0] want;
        int n = 0;
        want = ~(4'b0001 << k);
        while (an0 !== want && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL slot_timeout slot %0d an %b expected %b", k, an0, want);
        end
    endtask

    task automatic check_display(input string tag);
        int e;
        bit eo;
        int ed[4];
        logic [3:0] want_an;
        bit lead;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard_empty got 0 entries expected 1", tag);
            return;
        end
        e  = exp_q.pop_front();
        eo = ovf_q.pop_front();
        ed[0] = e % 10;
        ed[1] = (e / 10) % 10;
        ed[2] = (e / 100) % 10;
        ed[3] = (e / 1000) % 10;
        checks++;
        if (ovf0 !== eo || ovf1 !== eo) begin
            errors++;
            $display("FAIL %s ovf got %b/%b expected %b", tag, ovf0, ovf1, eo);
        end
        for (int k = 0; k < 4; k++) begin
            wait_slot(k);
            lead = (k >= 1);
            for (int j = k; j < 4; j++) if (ed[j] != 0) lead = 1'b0;
            want_an = lead ? 4'b1111 : ~(4'b0001 << k);
            checks++;
            if (digit0 !== 4'(ed[k]) || digit1 !== 4'(ed[k])) begin
                errors++;
                $display("FAIL %s digit slot %0d got %0d/%0d expected %0d", tag, k, digit0, digit1, ed[k]);
            end
            checks++;
            if (an1 !== want_an) begin
                errors++;
                $display("FAIL %s blank_an slot %0d got %b expected %b", tag, k, an1, want_an);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] want;
        rst = 1'b1;
        load = 1'b0;
        value = '0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (an0 !== 4'b1110 || digit0 !== 4'd0 || busy0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got an=%b digit=%0d busy=%b ovf=%b expected 1110 0 0 0",
                     an0, digit0, busy0, ovf0);
        end
        for (int c = 0; c < 16; c++) begin
            want = ~(4'b0001 << ((c / 4) % 4));
            checks++;
            if (an0 !== want) begin
                errors++;
                $display("FAIL scan_step cycle %0d got %b expected %b", c, an0, want);
            end
            want = (c / 4 % 4 == 0) ? 4'b1110 : 4'b1111;
            checks++;
            if (an1 !== want) begin
                errors++;
                $display("FAIL reset_blank cycle %0d got %b expected %b", c, an1, want);
            end
            step();
        end
    endtask

    task automatic test_convert();
        do_load(1234);
        wait_commit(1'b0);
        check_display("conv1234");
    endtask

    task automatic test_overflow();
        do_load(12000);
        wait_commit(1'b0);
        check_display("ovf12000");
        do_load(5);
        checks++;
        if (ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold got %b expected 1", ovf0);
        end
        wait_commit(1'b0);
        check_display("after_ovf5");
    endtask

    task automatic test_blanking();
        do_load(7);
        wait_commit(1'b0);
        check_display("blank7");
        do_load(0);
        wait_commit(1'b0);
        check_display("blank0");
        do_load(1005);
        wait_commit(1'b0);
        check_display("inner1005");
    endtask

    task automatic test_back_to_back();
        do_load(42);
        wait_commit(1'b1);
        repeat (3) step();
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL ignored_load got busy=%b expected 0", busy0);
        end
        check_display("ignore42");
    endtask

    task automatic test_reset_mid();
        do_load(8888);
        repeat (6) step();
        rst   = 1'b1;
        value = 14'd1234;
        load  = 1'b1;
        step();
        rst  = 1'b0;
        load = 1'b0;
        exp_q.delete();
        ovf_q.delete();
        checks++;
        if (busy0 !== 1'b0 || an0 !== 4'b1110 || digit0 !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b an=%b digit=%0d expected 0 1110 0", busy0, an0, digit0);
        end
        repeat (25) step();
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle got busy=%b expected 0", busy0);
        end
        exp_q.push_back(0);
        ovf_q.push_back(1'b0);
        check_display("mid_reset");
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
